// File: rtl/hex_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_ctrl_pkg
//  Description : Shared state encoding and display-select constants for the
//                hex display scan sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_scan_ctrl_pkg;

    localparam logic [1:0] C_ST_READ_REQ  = 2'd0;
    localparam logic [1:0] C_ST_READ_WAIT = 2'd1;
    localparam logic [1:0] C_ST_SHOW_ADDR = 2'd2;
    localparam logic [1:0] C_ST_SHOW_DATA = 2'd3;

    typedef enum logic [1:0] {
        READ_REQ  = C_ST_READ_REQ,
        READ_WAIT = C_ST_READ_WAIT,
        SHOW_ADDR = C_ST_SHOW_ADDR,
        SHOW_DATA = C_ST_SHOW_DATA
    } scan_state_t;

    localparam logic [10:0] SEL_ADDR = 11'd0;
    localparam logic [10:0] SEL_DATA = 11'd1;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/hex_scan_ctrl_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Loadable up-counter with enable and clear. Wraps to zero
//                after reaching the terminal value; term is high in an
//                enabled cycle whose count equals the terminal value.
//  Revision    : 1.0 - initial release
// ============================================================================
import hex_scan_ctrl_pkg::*;

module dwell_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] terminal,
    output logic             term
);

    logic [WIDTH-1:0] r_count;

    // Count while enabled; clear has priority over load, load over counting.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable) begin
            r_count <= (r_count == terminal) ? '0 : r_count + 1'b1;
        end
    end

    assign term = enable && (r_count == terminal);

endmodule
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_ctrl
//  Description : Debug display sequencer. Reads each register through the
//                debug port, latches it, then shows the address view followed
//                by the data view, advancing on a dwell timer or step pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
import hex_scan_ctrl_pkg::*;

module hex_scan_ctrl #(
    parameter int          DWELL_CYCLES = 50000000,
    parameter int          NUM_REGS     = 64,
    parameter int          RD_TIMEOUT   = 15,
    parameter logic [31:0] ERR_WORD     = ERR_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        auto_mode,
    input  logic        step,
    input  logic        pause,
    output logic        dbg_rd_req,
    output logic [5:0]  dbg_rd_addr,
    input  logic        dbg_rd_valid,
    input  logic [31:0] dbg_rd_data,
    output logic [10:0] sel,
    output logic [5:0]  rf_a,
    output logic [5:0]  rf_b,
    output logic [5:0]  rf_c,
    output logic [31:0] ra_data,
    output logic        rd_err
);

    localparam int                   c_dwell_w    = $clog2(DWELL_CYCLES);
    localparam logic [c_dwell_w-1:0] c_dwell_term = c_dwell_w'(DWELL_CYCLES - 1);
    localparam int                   c_to_w       = $clog2(RD_TIMEOUT + 1);
    localparam logic [c_to_w-1:0]    c_to_limit   = c_to_w'(RD_TIMEOUT - 1);
    localparam logic [5:0]           c_last_idx   = 6'(NUM_REGS - 1);

    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic [5:0]        r_index;
    logic              r_req;
    logic [10:0]       r_sel;
    logic [31:0]       r_ra_data;
    logic              r_rd_err;
    logic [c_to_w-1:0] r_to;

    logic [5:0]        w_index_inc;
    logic              w_in_show;
    logic              w_dwell_term;
    logic              w_advance;
    logic              w_rd_done;
    logic              w_rd_timeout;

    assign w_index_inc = (r_index == c_last_idx) ? 6'd0 : r_index + 6'd1;
    assign w_in_show   = (r_state == SHOW_ADDR) || (r_state == SHOW_DATA);
    // Step and timer expiry together still form a single advance.
    assign w_advance   = w_in_show && !pause && ((auto_mode && w_dwell_term) || step);

    // Dwell counter is frozen by pause and restarts on every advance and
    // whenever the sequencer is not showing a view.
    dwell_timer #(
        .WIDTH (c_dwell_w)
    ) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_advance || !w_in_show),
        .enable     (w_in_show && !pause),
        .load       (1'b0),
        .load_value ({c_dwell_w{1'b0}}),
        .terminal   (c_dwell_term),
        .term       (w_dwell_term)
    );

    // Next-state decode; a valid in the last timeout cycle beats the timeout.
    always_comb begin
        w_state_next = r_state;
        w_rd_done    = 1'b0;
        w_rd_timeout = 1'b0;
        case (r_state)
            READ_REQ:  w_state_next = READ_WAIT;
            READ_WAIT: begin
                if (dbg_rd_valid) begin
                    w_rd_done    = 1'b1;
                    w_state_next = SHOW_ADDR;
                end else if (r_to == c_to_limit) begin
                    w_rd_timeout = 1'b1;
                    w_state_next = SHOW_ADDR;
                end
            end
            SHOW_ADDR: if (w_advance) w_state_next = SHOW_DATA;
            SHOW_DATA: if (w_advance) w_state_next = READ_REQ;
            default:   w_state_next = READ_REQ;
        endcase
    end

    // State, registered outputs, read latch and index advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= READ_REQ;
            r_index   <= 6'd0;
            r_req     <= 1'b0;
            r_sel     <= SEL_ADDR;
            r_ra_data <= 32'd0;
            r_rd_err  <= 1'b0;
            r_to      <= '0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == READ_WAIT);
            r_sel   <= (w_state_next == SHOW_DATA) ? SEL_DATA : SEL_ADDR;
            r_to    <= ((r_state == READ_WAIT) && (w_state_next == READ_WAIT))
                       ? r_to + 1'b1 : '0;
            if (w_rd_done) begin
                r_ra_data <= dbg_rd_data;
            end else if (w_rd_timeout) begin
                r_ra_data <= ERR_WORD;
                r_rd_err  <= 1'b1;
            end
            if ((r_state == SHOW_DATA) && w_advance) begin
                r_index <= w_index_inc;
            end
        end
    end

    assign dbg_rd_req  = r_req;
    assign dbg_rd_addr = r_index;
    assign sel         = r_sel;
    assign rf_a        = r_index;
    assign rf_b        = w_index_inc;
    assign rf_c        = c_last_idx;
    assign ra_data     = r_ra_data;
    assign rd_err      = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hex_scan_ctrl
//  Description : Self-checking bench for hex_scan_ctrl with a register-file
//                responder feeding an expected-data queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

    localparam int          DWELL = 4;
    localparam int          NREGS = 3;
    localparam int          TMO   = 15;
    localparam logic [31:0] ERRW  = 32'hDEAD_BEEF;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        auto_mode = 1'b1;
    logic        step      = 1'b0;
    logic        pause     = 1'b0;
    logic        dbg_rd_req;
    logic [5:0]  dbg_rd_addr;
    logic        dbg_rd_valid;
    logic [31:0] dbg_rd_data;
    logic [10:0] sel;
    logic [5:0]  rf_a, rf_b, rf_c;
    logic [31:0] ra_data;
    logic        rd_err;

    int vectors     = 0;
    int miscompares = 0;

    // responder: 0 = valid 2 cycles into req, 1 = never (timeout),
    // 2 = silent with no expectation, 3 = valid exactly in the last allowed cycle
    int          resp_mode  = 0;
    int          age        = 0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data  = 32'd0;
    logic        man_valid  = 1'b0;
    logic [31:0] man_data   = 32'd0;
    logic [31:0] sb[$];

    assign dbg_rd_valid = resp_valid | man_valid;
    assign dbg_rd_data  = man_valid ? man_data : resp_data;

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .DWELL_CYCLES (DWELL),
        .NUM_REGS     (NREGS),
        .RD_TIMEOUT   (TMO),
        .ERR_WORD     (ERRW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .auto_mode    (auto_mode),
        .step         (step),
        .pause        (pause),
        .dbg_rd_req   (dbg_rd_req),
        .dbg_rd_addr  (dbg_rd_addr),
        .dbg_rd_valid (dbg_rd_valid),
        .dbg_rd_data  (dbg_rd_data),
        .sel          (sel),
        .rf_a         (rf_a),
        .rf_b         (rf_b),
        .rf_c         (rf_c),
        .ra_data      (ra_data),
        .rd_err       (rd_err)
    );

    // Register-file model: answers requests and records what the display must latch.
    always @(posedge clk) begin
        #2;
        if (dbg_rd_req) age = age + 1;
        else            age = 0;
        resp_valid = 1'b0;
        if (age == 1 && resp_mode == 1) sb.push_back(ERRW);
        if ((resp_mode == 0 && age == 2) || (resp_mode == 3 && age == TMO)) begin
            resp_valid = 1'b1;
            resp_data  = 32'h1000 + {26'd0, dbg_rd_addr};
            sb.push_back(resp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_read_done(input int budget, output bit ok, output int hi);
        logic last;
        last = dbg_rd_req;
        ok   = 1'b0;
        hi   = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (last && !dbg_rd_req) begin
                ok = 1'b1;
                break;
            end
            if (dbg_rd_req) hi++;
            last = dbg_rd_req;
        end
    endtask

    task automatic wait_addr_change(input logic [5:0] from, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dbg_rd_addr !== from) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if ({sel, dbg_rd_req, dbg_rd_addr} !== {11'd0, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL reset_ctrl: sel=%0d req=%0b addr=%0d want 0 0 0", sel, dbg_rd_req, dbg_rd_addr);
        end
        vectors++;
        if ({ra_data, rd_err} !== {32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_data: ra_data=%h rd_err=%0b want 0 0", ra_data, rd_err);
        end
        vectors++;
        if ({rf_a, rf_b, rf_c} !== {6'd0, 6'd1, 6'd2}) begin
            miscompares++;
            $display("FAIL reset_rf: rf_a=%0d rf_b=%0d rf_c=%0d want 0 1 2", rf_a, rf_b, rf_c);
        end
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic test_auto();
        bit ok; int hi; int n0; int n1; logic [31:0] want;
        wait_read_done(20, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || ra_data !== want || want !== 32'h1000) begin
            miscompares++;
            $display("FAIL auto_read0: ra_data=%h want %h (done=%0b)", ra_data, want, ok);
        end
        n0 = 0;
        while (sel === 11'd0 && n0 < 20) begin n0++; tick(); end
        n1 = 0;
        while (sel === 11'd1 && n1 < 20) begin n1++; tick(); end
        vectors++;
        if (n0 != DWELL || n1 != DWELL) begin
            miscompares++;
            $display("FAIL auto_dwell: addr view %0d data view %0d cycles, want %0d each", n0, n1, DWELL);
        end
        vectors++;
        if (dbg_rd_addr !== 6'd1 || rf_a !== 6'd1 || sel !== 11'd0) begin
            miscompares++;
            $display("FAIL auto_next: addr=%0d rf_a=%0d sel=%0d want 1 1 0", dbg_rd_addr, rf_a, sel);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_i [3] = '{6'd1, 6'd2, 6'd0};
        logic [5:0] exp_b [3] = '{6'd2, 6'd0, 6'd1};
        logic [5:0] cur; bit ok; int hi; logic [31:0] want;
        for (int k = 0; k < 3; k++) begin
            cur = dbg_rd_addr;
            vectors++;
            if (cur !== exp_i[k] || rf_b !== exp_b[k]) begin
                miscompares++;
                $display("FAIL wrap_idx%0d: addr=%0d rf_b=%0d want %0d %0d", k, cur, rf_b, exp_i[k], exp_b[k]);
            end
            wait_read_done(20, ok, hi);
            want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
            vectors++;
            if (!ok || ra_data !== want) begin
                miscompares++;
                $display("FAIL wrap_read%0d: ra_data=%h want %h (done=%0b)", k, ra_data, want, ok);
            end
            wait_addr_change(cur, 30, ok);
        end
        vectors++;
        if (dbg_rd_addr !== 6'd1) begin
            miscompares++;
            $display("FAIL wrap_loop: addr=%0d want 1", dbg_rd_addr);
        end
    endtask

    task automatic test_valid_at_limit();
        bit ok; int hi; logic [31:0] want;
        resp_mode = 3;
        wait_read_done(40, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || hi != TMO || ra_data !== want || rd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL limit_valid: req_cycles=%0d ra_data=%h rd_err=%0b want %0d %h 0", hi, ra_data, rd_err, TMO, want);
        end
        resp_mode = 0;
    endtask

    task automatic test_timeout();
        bit ok; int hi; logic [31:0] want;
        wait_addr_change(dbg_rd_addr, 30, ok);
        resp_mode = 1;
        wait_read_done(40, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || hi != TMO || ra_data !== want || ra_data !== ERRW || rd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout: req_cycles=%0d ra_data=%h rd_err=%0b want %0d %h 1", hi, ra_data, rd_err, TMO, ERRW);
        end
        resp_mode = 0;
        wait_read_done(40, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || ra_data !== want || rd_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: ra_data=%h rd_err=%0b want %h 1", ra_data, rd_err, want);
        end
    endtask

    task automatic test_step();
        bit ok; int hi; int chg; logic [5:0] base; logic [31:0] want;
        auto_mode = 1'b0;
        base = dbg_rd_addr;
        chg = 0;
        repeat (8) begin tick(); if (sel !== 11'd0 || dbg_rd_addr !== base) chg++; end
        vectors++;
        if (chg != 0) begin miscompares++; $display("FAIL step_idle_addr: %0d changes want 0", chg); end
        step = 1'b1; tick(); step = 1'b0;
        vectors++;
        if (sel !== 11'd1) begin miscompares++; $display("FAIL step_to_data: sel=%0d want 1", sel); end
        chg = 0;
        repeat (8) begin tick(); if (sel !== 11'd1) chg++; end
        vectors++;
        if (chg != 0) begin miscompares++; $display("FAIL step_idle_data: %0d changes want 0", chg); end
        step = 1'b1; tick(); step = 1'b0;
        vectors++;
        if (sel !== 11'd0 || dbg_rd_addr !== base + 6'd1) begin
            miscompares++;
            $display("FAIL step_to_read: sel=%0d addr=%0d want 0 %0d", sel, dbg_rd_addr, base + 6'd1);
        end
        tick();
        step = 1'b1; tick(); step = 1'b0;
        wait_read_done(20, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || ra_data !== want) begin
            miscompares++;
            $display("FAIL step_read: ra_data=%h want %h (done=%0b)", ra_data, want, ok);
        end
        chg = 0;
        repeat (8) begin tick(); if (sel !== 11'd0 || dbg_rd_addr !== base + 6'd1) chg++; end
        vectors++;
        if (chg != 0) begin miscompares++; $display("FAIL step_in_read_dropped: %0d changes want 0", chg); end
        step = 1'b1; tick(); step = 1'b0;
        repeat (3) tick();
        step = 1'b1; auto_mode = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if (sel !== 11'd0 || dbg_rd_addr !== base + 6'd2) begin
            miscompares++;
            $display("FAIL step_with_timer: sel=%0d addr=%0d want 0 %0d", sel, dbg_rd_addr, base + 6'd2);
        end
    endtask

    task automatic test_pause();
        bit ok; int hi; int chg; logic [31:0] want;
        wait_read_done(20, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || ra_data !== want) begin
            miscompares++;
            $display("FAIL pause_read: ra_data=%h want %h (done=%0b)", ra_data, want, ok);
        end
        repeat (2) tick();
        pause = 1'b1;
        chg = 0;
        for (int i = 0; i < 10; i++) begin
            step = (i == 5);
            tick();
            if (sel !== 11'd0) chg++;
        end
        step = 1'b0;
        vectors++;
        if (chg != 0) begin miscompares++; $display("FAIL pause_hold: %0d changes want 0", chg); end
        pause = 1'b0;
        tick();
        vectors++;
        if (sel !== 11'd0) begin miscompares++; $display("FAIL pause_resume1: sel=%0d want 0", sel); end
        tick();
        vectors++;
        if (sel !== 11'd1) begin miscompares++; $display("FAIL pause_resume2: sel=%0d want 1", sel); end
    endtask

    task automatic test_reset_mid_read();
        bit ok; int hi; logic [31:0] want;
        resp_mode = 2;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin tick(); ok = dbg_rd_req; end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL midread_req: req=%0b want 1", dbg_rd_req); end
        tick();
        reset = 1'b1;
        tick();
        vectors++;
        if ({sel, dbg_rd_req, dbg_rd_addr, ra_data, rd_err, rf_b} !== {11'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd1}) begin
            miscompares++;
            $display("FAIL midread_reset: sel=%0d req=%0b addr=%0d ra=%h err=%0b rf_b=%0d want 0 0 0 0 0 1",
                     sel, dbg_rd_req, dbg_rd_addr, ra_data, rd_err, rf_b);
        end
        sb.delete();
        reset = 1'b0;
        man_valid = 1'b1;
        man_data = 32'h5555_AAAA;
        tick();
        man_valid = 1'b0;
        resp_mode = 0;
        vectors++;
        if ({ra_data, dbg_rd_req, dbg_rd_addr, rd_err} !== {32'd0, 1'b1, 6'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midread_late: ra=%h req=%0b addr=%0d err=%0b want 0 1 0 0", ra_data, dbg_rd_req, dbg_rd_addr, rd_err);
        end
        wait_read_done(20, ok, hi);
        want = (sb.size() != 0) ? sb.pop_front() : 32'hx;
        vectors++;
        if (!ok || ra_data !== want || want !== 32'h1000) begin
            miscompares++;
            $display("FAIL midread_reread: ra_data=%h want %h (done=%0b)", ra_data, want, ok);
        end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_wrap();
        test_valid_at_limit();
        test_timeout();
        test_step();
        test_pause();
        test_reset_mid_read();
        repeat (2) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Debug display sequencer that walks the register file one index at a time.
- For each register it reads the contents through a req/valid debug read port, latches the word, then drives the 11-bit display-mux select and the register-address bus.
- The hex display shows the address view (select 0), then the latched data (select 1).
- Sits between the front-panel inputs (switch, step button), the register-file debug port and the hex display mux.

Parameters:
- DWELL_CYCLES, 50000000, cycles each view is held in auto mode (1 s at 50 MHz); must be >= 2.
- NUM_REGS, 64, number of register indices scanned (0..NUM_REGS-1); must be <= 64.
- RD_TIMEOUT, 15, max cycles from req to valid before the read is declared failed.
- ERR_WORD, 32'hDEAD_BEEF, value latched on read timeout.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- auto_mode  in  1  1 = advance on dwell timer; 0 = advance only on step.
- step  in  1  single-cycle pulse, already debounced and edge-detected; advances one view.
- pause  in  1  freezes the dwell counter and all advancing; an in-flight read still completes.
- dbg_rd_req  out  1  read request to register-file debug port.
- dbg_rd_addr  out  6  register index being read; stable while dbg_rd_req = 1.
- dbg_rd_valid  in  1  one-cycle pulse; dbg_rd_data is valid this cycle.
- dbg_rd_data  in  32  read data.
- sel  out  11  display mux select: 11'd0 = address view, 11'd1 = data view.
- rf_a  out  6  address field shown in address view; equals current index.
- rf_b  out  6  current index + 1 mod NUM_REGS (preview of next).
- rf_c  out  6  constant NUM_REGS-1 (scan limit).
- ra_data  out  32  latched register contents, fed to the mux data input.
- rd_err  out  1  sticky; set on any read timeout, cleared only by reset.

Behaviour:
- Reset values: state = READ_REQ, index = 0, sel = 0, dbg_rd_req = 0, dbg_rd_addr = 0, ra_data = 0, rd_err = 0, dwell counter = 0, timeout counter = 0. rf_b = 1, rf_c = NUM_REGS-1.
- Reset mid-read abandons the read; a dbg_rd_valid arriving after reset is ignored unless a new req is outstanding.
- States:
  - READ_REQ: dbg_rd_req = 1, dbg_rd_addr = index. Next cycle -> READ_WAIT.
  - READ_WAIT: dbg_rd_req stays 1; timeout counter increments each cycle.
    - On dbg_rd_valid: ra_data <= dbg_rd_data; dbg_rd_req drops the following cycle; -> SHOW_ADDR.
    - If the counter reaches RD_TIMEOUT with no valid: ra_data <= ERR_WORD, rd_err <= 1, -> SHOW_ADDR.
    - valid in the same cycle the counter hits RD_TIMEOUT: valid wins, no error.
  - SHOW_ADDR: sel = 0; dwell counter runs. Advance -> SHOW_DATA.
  - SHOW_DATA: sel = 1. Advance -> index <= (index == NUM_REGS-1) ? 0 : index + 1; -> READ_REQ.
- Advance condition in SHOW states: (auto_mode && dwell == DWELL_CYCLES-1 && !pause) || (step && !pause).
  - Dwell counter clears on every advance and on entry to a SHOW state.
  - step and timer expiry in the same cycle produce one advance, not two.
- step or pause during READ_REQ/READ_WAIT: step is dropped (not queued); pause does not stop the read.
- auto_mode toggling takes effect the next cycle; the dwell counter is not reset by the toggle.
- Latency: index change -> ra_data updated = 2 + read latency cycles. sel changes exactly 1 cycle after the advance condition.
- sel and ra_data are registered (no glitch to the display); sel upper bits are always 0.

Decomposition:
- Shared package holds:
  - state encoding: READ_REQ = 0, READ_WAIT = 1, SHOW_ADDR = 2, SHOW_DATA = 3;
  - display select constants SEL_ADDR = 11'd0, SEL_DATA = 11'd1;
  - ERR_WORD default.
- One natural sub-module, dwell_timer: a loadable counter with enable/clear, producing a terminal pulse. It is reused by other front-panel blocks.

Test Plan:
- Reset, auto_mode = 1, DWELL_CYCLES = 4, responder returns valid 2 cycles after req with data = 32'h1000+addr -> index 0: ra_data = 32'h1000, sel = 0 for 4 cycles, then 1 for 4 cycles, then dbg_rd_addr = 1.
- Scan with NUM_REGS = 3 through a full loop -> after index 2 SHOW_DATA, dbg_rd_addr returns to 0; rf_b sequence 1, 2, 0.
- Responder never asserts valid -> after 15 cycles ra_data = 32'hDEADBEEF, rd_err = 1 and stays 1 through later good reads.
- auto_mode = 0, step pulses at arbitrary times -> exactly one view change per pulse; a step during READ_WAIT causes no change; step coinciding with timer expiry gives a single advance.
- pause = 1 in SHOW_ADDR with the dwell counter at 2 -> sel holds indefinitely; after release, the advance comes 2 cycles later (counter resumed, not cleared).
- reset asserted in READ_WAIT, then a late valid pulse -> outputs at reset values, late data not latched, new read of index 0 issued the cycle after reset deasserts.
